// File: rtl/alu_issue_sequencer_if.sv
// Bundle of the instruction handshake, host write/debug port, ALU operand/result
// and completion signals for alu_issue_sequencer.
interface alu_issue_sequencer_if #(
   parameter int AW = 3
);
   // instr_valid/instr_ready: an instruction transfers on a rising edge where both
   // are high; the offering side holds valid and all instr_* stable until then.
   logic          instr_valid;
   logic          instr_ready;
   logic [3:0]    instr_opcode;
   logic [AW-1:0] instr_rd;
   logic [AW-1:0] instr_rs1;
   logic [AW-1:0] instr_rs2;
   logic          instr_imm_en;
   logic [7:0]    instr_imm;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [AW-1:0] dbg_addr;
   logic [7:0]    dbg_data;

   logic [7:0]    op1;
   logic [7:0]    op2;
   logic [3:0]    opcode;
   logic [8:0]    alu_result;
   logic          alu_carry;
   logic          alu_zero;

   logic          done_valid;
   logic [AW-1:0] done_rd;
   logic [8:0]    done_data;
   logic          carry_q;
   logic          zero_q;
   logic          busy;
   logic [1:0]    dbg_state;

   modport slave (
      input  instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
             instr_imm_en, instr_imm, wr_en, wr_addr, wr_data, dbg_addr,
             alu_result, alu_carry, alu_zero,
      output instr_ready, dbg_data, op1, op2, opcode, done_valid, done_rd,
             done_data, carry_q, zero_q, busy, dbg_state
   );

   modport master (
      output instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
             instr_imm_en, instr_imm, wr_en, wr_addr, wr_data, dbg_addr,
             alu_result, alu_carry, alu_zero,
      input  instr_ready, dbg_data, op1, op2, opcode, done_valid, done_rd,
             done_data, carry_q, zero_q, busy, dbg_state
   );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Sequences one instruction at a time through an external 1-cycle ALU:
// operand read/issue from an 8x8 register file, then result/flag writeback.
module alu_issue_sequencer #(
   parameter int NREGS = 8,
   parameter int AW    = 3
) (
   input  logic                   clock,
   input  logic                   resetn,
   alu_issue_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WB    = 2'd2
   } state_t;

   state_t        state_q;
   logic [7:0]    regs_q [NREGS];
   logic [7:0]    op1_q;
   logic [7:0]    op2_q;
   logic [3:0]    opcode_q;
   logic [AW-1:0] rd_q;
   logic          ready_q;
   logic          busy_q;
   logic          done_valid_q;
   logic [AW-1:0] done_rd_q;
   logic [8:0]    done_data_q;
   logic          carry_flag_q;
   logic          zero_flag_q;

   logic          accept;
   logic [7:0]    op1_d;
   logic [7:0]    op2_d;

   // Operands come from the pre-edge register contents, so a host write on the
   // acceptance edge is not seen by the instruction being accepted.
   always_comb begin
      accept = ready_q & bus.instr_valid;
      op1_d  = regs_q[bus.instr_rs1];
      op2_d  = bus.instr_imm_en ? bus.instr_imm : regs_q[bus.instr_rs2];
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         op1_q        <= '0;
         op2_q        <= '0;
         opcode_q     <= '0;
         rd_q         <= '0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_rd_q    <= '0;
         done_data_q  <= '0;
         carry_flag_q <= 1'b0;
         zero_flag_q  <= 1'b0;
      end else begin
         done_valid_q <= 1'b0;
         if (bus.wr_en) regs_q[bus.wr_addr] <= bus.wr_data;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op1_q    <= op1_d;
                  op2_q    <= op2_d;
                  opcode_q <= bus.instr_opcode;
                  rd_q     <= bus.instr_rd;
                  state_q  <= S_ISSUE;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            S_ISSUE: begin
               state_q <= S_WB;
            end
            S_WB: begin
               // Placed after the host write so writeback wins an address clash.
               regs_q[rd_q] <= bus.alu_result[7:0];
               carry_flag_q <= bus.alu_carry;
               zero_flag_q  <= bus.alu_zero;
               done_data_q  <= bus.alu_result;
               done_rd_q    <= rd_q;
               done_valid_q <= 1'b1;
               state_q      <= S_IDLE;
               ready_q      <= 1'b1;
               busy_q       <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.instr_ready = ready_q;
   assign bus.busy        = busy_q;
   assign bus.dbg_data    = regs_q[bus.dbg_addr];
   assign bus.op1         = op1_q;
   assign bus.op2         = op2_q;
   assign bus.opcode      = opcode_q;
   assign bus.done_valid  = done_valid_q;
   assign bus.done_rd     = done_rd_q;
   assign bus.done_data   = done_data_q;
   assign bus.carry_q     = carry_flag_q;
   assign bus.zero_q      = zero_flag_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Testbench for alu_issue_sequencer: adder ALU stub, vector table, corner-case
// sequences and randomized instructions checked against a register-file model.
module tb_alu_issue_sequencer;
   localparam int AW = 3;

   // ---------------- clock / reset ----------------
   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   alu_issue_sequencer_if #(.AW(AW)) bus ();

   alu_issue_sequencer #(.NREGS(8), .AW(AW)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   // ALU stub: registered 9-bit add, flags derived from the sum.
   logic [8:0] stub_sum;
   assign stub_sum = {1'b0, bus.op1} + {1'b0, bus.op2};
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         bus.alu_result <= '0;
         bus.alu_carry  <= 1'b0;
         bus.alu_zero   <= 1'b0;
      end else begin
         bus.alu_result <= stub_sum;
         bus.alu_carry  <= stub_sum[8];
         bus.alu_zero   <= (stub_sum[7:0] == 8'h00);
      end
   end

   // ---------------- checking / model ----------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  m_regs [8];
   logic        m_carry;
   logic        m_zero;
   logic [11:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every completion must match the oldest outstanding expectation.
   always @(negedge clock) begin : done_monitor
      logic [11:0] e;
      if (resetn && bus.done_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(bus.done_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("done_rd", 32'(bus.done_rd), 32'(e[11:9]));
            chk("done_data", 32'(bus.done_data), 32'(e[8:0]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_carry = 1'b0;
      m_zero  = 1'b0;
   endtask

   task automatic host_write(input logic [2:0] a, input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
      m_regs[a]   = d;
   endtask

   task automatic check_reg(input logic [2:0] a, input logic [7:0] exp);
      bus.dbg_addr = a;
      #1;
      chk($sformatf("dbg_r%0d", a), 32'(bus.dbg_data), 32'(exp));
   endtask

   // Offers an instruction, returns just after the accepting edge.
   task automatic start_issue(input logic [2:0] rd, input logic [2:0] rs1,
                              input logic [2:0] rs2, input logic ie,
                              input logic [7:0] imm, input logic [3:0] opc);
      logic [7:0] o1, o2;
      logic [8:0] s;
      int k;
      bus.instr_rd     = rd;
      bus.instr_rs1    = rs1;
      bus.instr_rs2    = rs2;
      bus.instr_imm_en = ie;
      bus.instr_imm    = imm;
      bus.instr_opcode = opc;
      bus.instr_valid  = 1'b1;
      k = 0;
      while (!bus.instr_ready && k < 8) begin
         tick();
         k++;
      end
      if (!bus.instr_ready) chk("accept_timeout", 32'(bus.instr_ready), 32'd1);
      o1 = m_regs[rs1];
      o2 = ie ? imm : m_regs[rs2];
      s  = {1'b0, o1} + {1'b0, o2};
      tick();
      bus.instr_valid = 1'b0;
      bus.wr_en       = 1'b0;
      chk("issue_op1", 32'(bus.op1), 32'(o1));
      chk("issue_op2", 32'(bus.op2), 32'(o2));
      chk("issue_opcode", 32'(bus.opcode), 32'(opc));
      chk("issue_busy", 32'(bus.busy), 32'd1);
      chk("issue_ready", 32'(bus.instr_ready), 32'd0);
      exp_q.push_back({rd, s});
      m_regs[rd] = s[7:0];
      m_carry    = s[8];
      m_zero     = (s[7:0] == 8'h00);
   endtask

   // Called right after start_issue: done must appear exactly two edges after accept.
   task automatic finish_issue();
      tick();
      chk("done_early", 32'(bus.done_valid), 32'd0);
      tick();
      chk("done_latency", 32'(bus.done_valid), 32'd1);
      chk("carry_q", 32'(bus.carry_q), 32'(m_carry));
      chk("zero_q", 32'(bus.zero_q), 32'(m_zero));
      chk("ready_after_wb", 32'(bus.instr_ready), 32'd1);
      chk("busy_after_wb", 32'(bus.busy), 32'd0);
   endtask

   task automatic run_issue(input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic ie,
                            input logic [7:0] imm, input logic [3:0] opc);
      start_issue(rd, rs1, rs2, ie, imm, opc);
      finish_issue();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [2:0] rd, rs1, rs2;
      logic       ie;
      logic [7:0] imm;
      logic [3:0] opc;
      logic [7:0] pre1, pre2;
      logic [7:0] e_op1, e_op2;
      logic [8:0] e_data;
      logic       e_c, e_z;
   } vec_t;

   vec_t vecs [6];

   initial begin : global_timeout
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [2:0] r_rd, r_rs1, r_rs2, r_a;
      logic [7:0] r_d;

      vecs[0] = '{3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 4'h0, 8'hBA, 8'hAB, 8'hBA, 8'hAB, 9'h165, 1'b1, 1'b0};
      vecs[1] = '{3'd4, 3'd4, 3'd0, 1'b1, 8'hFF, 4'h1, 8'h01, 8'h00, 8'h01, 8'hFF, 9'h100, 1'b1, 1'b1};
      vecs[2] = '{3'd5, 3'd5, 3'd6, 1'b0, 8'h00, 4'h2, 8'h10, 8'h20, 8'h10, 8'h20, 9'h030, 1'b0, 1'b0};
      vecs[3] = '{3'd7, 3'd7, 3'd0, 1'b0, 8'h00, 4'h3, 8'h00, 8'h00, 8'h00, 8'h00, 9'h000, 1'b0, 1'b1};
      vecs[4] = '{3'd2, 3'd6, 3'd6, 1'b0, 8'h00, 4'h9, 8'h80, 8'h80, 8'h80, 8'h80, 9'h100, 1'b1, 1'b1};
      vecs[5] = '{3'd1, 3'd1, 3'd0, 1'b1, 8'h7F, 4'hF, 8'h01, 8'h00, 8'h01, 8'h7F, 9'h080, 1'b0, 1'b0};

      bus.instr_valid  = 1'b0;
      bus.instr_opcode = '0;
      bus.instr_rd     = '0;
      bus.instr_rs1    = '0;
      bus.instr_rs2    = '0;
      bus.instr_imm_en = 1'b0;
      bus.instr_imm    = '0;
      bus.wr_en        = 1'b0;
      bus.wr_addr      = '0;
      bus.wr_data      = '0;
      bus.dbg_addr     = '0;
      model_reset();

      // Reset state while resetn is held low.
      repeat (2) tick();
      chk("rst_ready", 32'(bus.instr_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
      chk("rst_done_rd", 32'(bus.done_rd), 32'd0);
      chk("rst_done_data", 32'(bus.done_data), 32'd0);
      chk("rst_carry", 32'(bus.carry_q), 32'd0);
      chk("rst_zero", 32'(bus.zero_q), 32'd0);
      chk("rst_op1", 32'(bus.op1), 32'd0);
      chk("rst_op2", 32'(bus.op2), 32'd0);
      chk("rst_opcode", 32'(bus.opcode), 32'd0);
      for (int i = 0; i < 8; i++) check_reg(3'(i), 8'h00);
      tick();
      resetn = 1'b1;
      tick();

      // Table-driven vectors.
      for (int v = 0; v < 6; v++) begin
         host_write(vecs[v].rs1, vecs[v].pre1);
         if (!vecs[v].ie) host_write(vecs[v].rs2, vecs[v].pre2);
         run_issue(vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].ie, vecs[v].imm, vecs[v].opc);
         chk($sformatf("vec%0d_op1", v), 32'(bus.op1), 32'(vecs[v].e_op1));
         chk($sformatf("vec%0d_op2", v), 32'(bus.op2), 32'(vecs[v].e_op2));
         chk($sformatf("vec%0d_data", v), 32'(bus.done_data), 32'(vecs[v].e_data));
         chk($sformatf("vec%0d_carry", v), 32'(bus.carry_q), 32'(vecs[v].e_c));
         chk($sformatf("vec%0d_zero", v), 32'(bus.zero_q), 32'(vecs[v].e_z));
         check_reg(vecs[v].rd, vecs[v].e_data[7:0]);
      end

      // Back-to-back with instr_valid held high; second reads the first's rd.
      host_write(3'd1, 8'h10);
      host_write(3'd2, 8'h05);
      chk("b2b_ready_idle", 32'(bus.instr_ready), 32'd1);
      bus.instr_rd = 3'd3; bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd2;
      bus.instr_imm_en = 1'b0; bus.instr_imm = 8'h00; bus.instr_opcode = 4'h4;
      bus.instr_valid = 1'b1;
      tick();
      exp_q.push_back({3'd3, 9'h015});
      m_regs[3] = 8'h15; m_carry = 1'b0; m_zero = 1'b0;
      bus.instr_rd = 3'd4; bus.instr_rs1 = 3'd3; bus.instr_rs2 = 3'd3; bus.instr_opcode = 4'h5;
      chk("b2b_ready_c1", 32'(bus.instr_ready), 32'd0);
      chk("b2b_op1_first", 32'(bus.op1), 32'h10);
      tick();
      chk("b2b_ready_c2", 32'(bus.instr_ready), 32'd0);
      tick();
      chk("b2b_ready_c3", 32'(bus.instr_ready), 32'd1);
      chk("b2b_done_first", 32'(bus.done_valid), 32'd1);
      tick();
      bus.instr_valid = 1'b0;
      chk("b2b_second_accepted", 32'(bus.busy), 32'd1);
      chk("b2b_op1_second", 32'(bus.op1), 32'h15);
      chk("b2b_op2_second", 32'(bus.op2), 32'h15);
      exp_q.push_back({3'd4, 9'h02A});
      m_regs[4] = 8'h2A; m_carry = 1'b0; m_zero = 1'b0;
      finish_issue();
      check_reg(3'd4, 8'h2A);

      // Host write colliding with writeback to the same register.
      host_write(3'd1, 8'hBA);
      host_write(3'd2, 8'hAB);
      start_issue(3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 4'h6);
      tick();
      bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 8'h55;
      tick();
      bus.wr_en = 1'b0;
      chk("coll_done", 32'(bus.done_valid), 32'd1);
      check_reg(3'd3, 8'h65);

      // Host write to rs1 in the acceptance cycle: old operand used.
      host_write(3'd1, 8'h20);
      host_write(3'd2, 8'h03);
      bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 8'h99;
      start_issue(3'd5, 3'd1, 3'd2, 1'b0, 8'h00, 4'h7);
      m_regs[1] = 8'h99;
      chk("accw_op1_old", 32'(bus.op1), 32'h20);
      finish_issue();
      check_reg(3'd1, 8'h99);
      check_reg(3'd5, 8'h23);

      // Reset during ISSUE discards the instruction.
      host_write(3'd1, 8'h03);
      host_write(3'd2, 8'h04);
      start_issue(3'd6, 3'd1, 3'd2, 1'b0, 8'h00, 4'h8);
      resetn = 1'b0;
      #1;
      void'(exp_q.pop_back());
      model_reset();
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_ready", 32'(bus.instr_ready), 32'd1);
      chk("midrst_op1", 32'(bus.op1), 32'd0);
      check_reg(3'd6, 8'h00);
      tick();
      tick();
      chk("midrst_no_done", 32'(bus.done_valid), 32'd0);
      resetn = 1'b1;
      tick();
      chk("postrst_no_done", 32'(bus.done_valid), 32'd0);
      check_reg(3'd6, 8'h00);
      check_reg(3'd1, 8'h00);
      host_write(3'd1, 8'h03);
      host_write(3'd2, 8'h04);
      run_issue(3'd6, 3'd1, 3'd2, 1'b0, 8'h00, 4'h8);
      check_reg(3'd6, 8'h07);

      // Randomized instructions against the model.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            r_a = 3'($urandom_range(0, 7));
            r_d = 8'($urandom_range(0, 255));
            host_write(r_a, r_d);
         end
         repeat ($urandom_range(0, 2)) tick();
         r_rd  = 3'($urandom_range(0, 7));
         r_rs1 = 3'($urandom_range(0, 7));
         r_rs2 = 3'($urandom_range(0, 7));
         run_issue(r_rd, r_rs1, r_rs2, 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
         check_reg(r_rd, m_regs[r_rd]);
         r_a = 3'($urandom_range(0, 7));
         check_reg(r_a, m_regs[r_a]);
      end

      tick();
      tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
